// File: rtl/set_bit_iterator.sv
// set_bit_iterator
//   Accepts one DATA_WIDTH-bit word per din handshake and emits, one per dout
//   handshake, the index of every set bit, lowest first. Each index is the
//   trailing-zero count of the held word; the lowest set bit is cleared after
//   each emitted beat. An all-zero word yields a single beat with
//   dout = DATA_WIDTH and dout_empty = 1.
//
// Ports
//   clk        in   rising-edge clock
//   resetn     in   asynchronous active-low reset
//   din        in   word to scan
//   din_valid  in   din is valid
//   din_ready  out  word can be accepted this cycle (combinational from dout_ready)
//   dout       out  bit index, DATA_WIDTH for an all-zero word, 0 when idle
//   dout_valid out  dout/dout_last/dout_empty are valid
//   dout_ready in   consumer accepts dout this cycle
//   dout_last  out  final index of the current word
//   dout_empty out  current word was all-zero
module set_bit_iterator #(
   parameter int unsigned DATA_WIDTH = 32,
   localparam int unsigned IW = $clog2(DATA_WIDTH) + 1
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  din_valid,
   output logic                  din_ready,
   output logic [IW-1:0]         dout,
   output logic                  dout_valid,
   input  logic                  dout_ready,
   output logic                  dout_last,
   output logic                  dout_empty
);

   typedef enum logic {IDLE, SCAN} state_t;

   localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] word_q, word_d;
   logic                  empty_q, empty_d;

   logic [DATA_WIDTH-1:0] cleared;
   logic                  at_most_one;
   logic [IW-1:0]         tz;
   logic                  found;
   logic                  fire, done, accept;

   // word with its lowest set bit removed; zero means at most one bit was set
   assign cleared     = word_q & (word_q - ONE);
   assign at_most_one = (cleared == '0);

   always_comb begin
      tz    = IW'(DATA_WIDTH);
      found = 1'b0;
      for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
         if (!found && word_q[i]) begin
            tz    = i[IW-1:0];
            found = 1'b1;
         end
      end
   end

   assign dout_valid = (state_q == SCAN);
   assign fire       = dout_valid && dout_ready;
   assign done       = fire && at_most_one;
   assign din_ready  = (state_q == IDLE) || done;
   assign accept     = din_valid && din_ready;

   assign dout       = dout_valid ? tz : '0;
   assign dout_last  = dout_valid && at_most_one;
   assign dout_empty = dout_valid && empty_q;

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      empty_d = empty_q;
      if (accept) begin
         // a new word may replace the final beat in the same cycle
         state_d = SCAN;
         word_d  = din;
         empty_d = (din == '0);
      end else if (done) begin
         state_d = IDLE;
      end else if (fire) begin
         word_d  = cleared;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         word_q  <= '0;
         empty_q <= 1'b0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         empty_q <= empty_d;
      end
   end

endmodule

// File: tb/tb_set_bit_iterator.sv
module tb_set_bit_iterator;

   logic       clk = 1'b0;
   logic       resetn;

   logic [7:0] din8;
   logic       din_valid8, din_ready8, dout_valid8, dout_ready8, dout_last8, dout_empty8;
   logic [3:0] dout8;

   logic [31:0] din32;
   logic        din_valid32, din_ready32, dout_valid32, dout_ready32, dout_last32, dout_empty32;
   logic [5:0]  dout32;

   int n_checks = 0;
   int n_fail   = 0;

   logic [6:0] obs8;
   logic [8:0] obs32;
   logic [6:0] exp8;
   logic [8:0] exp32;

   always #5 clk = ~clk;

   assign obs8  = {dout_valid8, dout_last8, dout_empty8, dout8};
   assign obs32 = {dout_valid32, dout_last32, dout_empty32, dout32};

   set_bit_iterator #(.DATA_WIDTH(8)) u_dut8 (
      .clk(clk), .resetn(resetn),
      .din(din8), .din_valid(din_valid8), .din_ready(din_ready8),
      .dout(dout8), .dout_valid(dout_valid8), .dout_ready(dout_ready8),
      .dout_last(dout_last8), .dout_empty(dout_empty8)
   );

   set_bit_iterator #(.DATA_WIDTH(32)) u_dut32 (
      .clk(clk), .resetn(resetn),
      .din(din32), .din_valid(din_valid32), .din_ready(din_ready32),
      .dout(dout32), .dout_valid(dout_valid32), .dout_ready(dout_ready32),
      .dout_last(dout_last32), .dout_empty(dout_empty32)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      din8 = '0; din_valid8 = 1'b0; dout_ready8 = 1'b1;
      din32 = '0; din_valid32 = 1'b0; dout_ready32 = 1'b1;
      tick();
      tick();
      exp8 = '0;
      n_checks++;
      if (obs8 !== exp8) begin
         n_fail++; $display("FAIL reset8_outputs: got %h want %h", obs8, exp8);
      end
      n_checks++;
      if (din_ready8 !== 1'b1) begin
         n_fail++; $display("FAIL reset8_din_ready: got %b want 1", din_ready8);
      end
      exp32 = '0;
      n_checks++;
      if (obs32 !== exp32) begin
         n_fail++; $display("FAIL reset32_outputs: got %h want %h", obs32, exp32);
      end
      resetn = 1'b1;
      tick();
      n_checks++;
      if (obs8 !== 7'h00 || din_ready8 !== 1'b1) begin
         n_fail++; $display("FAIL after_release: got %h/%b want 00/1", obs8, din_ready8);
      end
   endtask

   // 1010_0100 -> 2, 5, 7
   task automatic test_sparse();
      din8 = 8'b1010_0100; din_valid8 = 1'b1; dout_ready8 = 1'b1;
      n_checks++;
      if (din_ready8 !== 1'b1) begin
         n_fail++; $display("FAIL sparse_idle_ready: got %b want 1", din_ready8);
      end
      tick();
      din_valid8 = 1'b0;
      exp8 = {1'b1, 1'b0, 1'b0, 4'd2};
      n_checks++;
      if (obs8 !== exp8) begin
         n_fail++; $display("FAIL sparse_beat2: got %h want %h", obs8, exp8);
      end
      n_checks++;
      if (din_ready8 !== 1'b0) begin
         n_fail++; $display("FAIL sparse_busy_ready: got %b want 0", din_ready8);
      end
      tick();
      exp8 = {1'b1, 1'b0, 1'b0, 4'd5};
      n_checks++;
      if (obs8 !== exp8) begin
         n_fail++; $display("FAIL sparse_beat5: got %h want %h", obs8, exp8);
      end
      tick();
      exp8 = {1'b1, 1'b1, 1'b0, 4'd7};
      n_checks++;
      if (obs8 !== exp8) begin
         n_fail++; $display("FAIL sparse_beat7: got %h want %h", obs8, exp8);
      end
      n_checks++;
      if (din_ready8 !== 1'b1) begin
         n_fail++; $display("FAIL sparse_last_ready: got %b want 1", din_ready8);
      end
      tick();
      n_checks++;
      if (obs8 !== 7'h00) begin
         n_fail++; $display("FAIL sparse_idle: got %h want 00", obs8);
      end
   endtask

   task automatic test_empty();
      din8 = 8'h00; din_valid8 = 1'b1; dout_ready8 = 1'b1;
      tick();
      din_valid8 = 1'b0;
      exp8 = {1'b1, 1'b1, 1'b1, 4'd8};
      n_checks++;
      if (obs8 !== exp8) begin
         n_fail++; $display("FAIL empty_beat: got %h want %h", obs8, exp8);
      end
      tick();
      n_checks++;
      if (obs8 !== 7'h00 || din_ready8 !== 1'b1) begin
         n_fail++; $display("FAIL empty_idle: got %h/%b want 00/1", obs8, din_ready8);
      end
   endtask

   // 0xFF with dout_ready alternating 0,1: each index held for two cycles
   task automatic test_stall();
      din8 = 8'hFF; din_valid8 = 1'b1; dout_ready8 = 1'b1;
      tick();
      din_valid8 = 1'b0;
      for (int c = 0; c < 16; c++) begin
         dout_ready8 = (c % 2 == 1);
         exp8 = {1'b1, (c / 2 == 7), 1'b0, 4'(c / 2)};
         n_checks++;
         if (obs8 !== exp8) begin
            n_fail++; $display("FAIL stall_cycle%0d: got %h want %h", c, obs8, exp8);
         end
         tick();
      end
      dout_ready8 = 1'b1;
      n_checks++;
      if (obs8 !== 7'h00) begin
         n_fail++; $display("FAIL stall_idle: got %h want 00", obs8);
      end
   endtask

   task automatic test_back_to_back();
      din8 = 8'h80; din_valid8 = 1'b1; dout_ready8 = 1'b1;
      tick();
      din8 = 8'h01;
      exp8 = {1'b1, 1'b1, 1'b0, 4'd7};
      n_checks++;
      if (obs8 !== exp8 || din_ready8 !== 1'b1) begin
         n_fail++; $display("FAIL b2b_beat7: got %h/%b want %h/1", obs8, din_ready8, exp8);
      end
      tick();
      din_valid8 = 1'b0;
      exp8 = {1'b1, 1'b1, 1'b0, 4'd0};
      n_checks++;
      if (obs8 !== exp8) begin
         n_fail++; $display("FAIL b2b_beat0: got %h want %h", obs8, exp8);
      end
      tick();
      n_checks++;
      if (obs8 !== 7'h00) begin
         n_fail++; $display("FAIL b2b_idle: got %h want 00", obs8);
      end
   endtask

   task automatic test_reset_mid();
      din8 = 8'h0F; din_valid8 = 1'b1; dout_ready8 = 1'b1;
      tick();
      din_valid8 = 1'b0;
      exp8 = {1'b1, 1'b0, 1'b0, 4'd0};
      n_checks++;
      if (obs8 !== exp8) begin
         n_fail++; $display("FAIL midrst_beat0: got %h want %h", obs8, exp8);
      end
      tick();
      #2 resetn = 1'b0;
      #1;
      n_checks++;
      if (obs8 !== 7'h00) begin
         n_fail++; $display("FAIL midrst_async_drop: got %h want 00", obs8);
      end
      tick();
      resetn = 1'b1;
      n_checks++;
      if (din_ready8 !== 1'b1 || obs8 !== 7'h00) begin
         n_fail++; $display("FAIL midrst_release: got %h/%b want 00/1", obs8, din_ready8);
      end
      din8 = 8'h10; din_valid8 = 1'b1;
      tick();
      din_valid8 = 1'b0;
      exp8 = {1'b1, 1'b1, 1'b0, 4'd4};
      n_checks++;
      if (obs8 !== exp8) begin
         n_fail++; $display("FAIL midrst_beat4: got %h want %h", obs8, exp8);
      end
      tick();
      n_checks++;
      if (obs8 !== 7'h00) begin
         n_fail++; $display("FAIL midrst_idle: got %h want 00", obs8);
      end
   endtask

   task automatic test_wide();
      din32 = 32'h8000_0001; din_valid32 = 1'b1; dout_ready32 = 1'b1;
      tick();
      din_valid32 = 1'b0;
      exp32 = {1'b1, 1'b0, 1'b0, 6'd0};
      n_checks++;
      if (obs32 !== exp32) begin
         n_fail++; $display("FAIL wide_beat0: got %h want %h", obs32, exp32);
      end
      tick();
      exp32 = {1'b1, 1'b1, 1'b0, 6'd31};
      n_checks++;
      if (obs32 !== exp32) begin
         n_fail++; $display("FAIL wide_beat31: got %h want %h", obs32, exp32);
      end
      tick();
      n_checks++;
      if (obs32 !== 9'h000 || din_ready32 !== 1'b1) begin
         n_fail++; $display("FAIL wide_idle: got %h/%b want 000/1", obs32, din_ready32);
      end
      din32 = 32'h0; din_valid32 = 1'b1;
      tick();
      din_valid32 = 1'b0;
      exp32 = {1'b1, 1'b1, 1'b1, 6'd32};
      n_checks++;
      if (obs32 !== exp32) begin
         n_fail++; $display("FAIL wide_empty: got %h want %h", obs32, exp32);
      end
      tick();
      n_checks++;
      if (obs32 !== 9'h000) begin
         n_fail++; $display("FAIL wide_empty_idle: got %h want 000", obs32);
      end
   endtask

   initial begin
      test_reset();
      test_sparse();
      test_empty();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      test_wide();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
